// File: rtl/tl_ul_arbiter_pkg.sv
// Shared definitions for the TileLink-UL master arbiter.
//   - A/D channel opcode constants used by masters and the bench
//   - arb_state_t : A-channel grant FSM state
package tl_ul_arbiter_pkg;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;
    localparam logic [2:0] ACK         = 3'd0;
    localparam logic [2:0] ACK_DATA    = 3'd1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/tl_ul_arbiter_if.sv
// TileLink-UL A/D channel bundle for N lanes (one lane per master).
// Upstream side of the arbiter uses N = NUM_MASTERS, SRC_W = SID_WIDTH;
// downstream side uses N = 1, SRC_W = SID_WIDTH + master-index width.
//   master modport : drives A, receives D (a requester)
//   slave  modport : receives A, drives D (a responder)
interface tl_ul_arbiter_if #(
    parameter int N     = 2,
    parameter int XLEN  = 32,
    parameter int SRC_W = 2
);
    logic [N-1:0]                 a_valid;
    logic [N-1:0]                 a_ready;
    logic [N-1:0][2:0]            a_opcode;
    logic [N-1:0][2:0]            a_param;
    logic [N-1:0][2:0]            a_size;
    logic [N-1:0][SRC_W-1:0]      a_source;
    logic [N-1:0][XLEN-1:0]       a_address;
    logic [N-1:0][XLEN/8-1:0]     a_mask;
    logic [N-1:0][XLEN-1:0]       a_data;

    logic [N-1:0]                 d_valid;
    logic [N-1:0]                 d_ready;
    logic [N-1:0][2:0]            d_opcode;
    logic [N-1:0][1:0]            d_param;
    logic [N-1:0][2:0]            d_size;
    logic [N-1:0][SRC_W-1:0]      d_source;
    logic [N-1:0][XLEN-1:0]       d_data;
    logic [N-1:0]                 d_corrupt;
    logic [N-1:0]                 d_denied;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_data, d_corrupt, d_denied,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_data, d_corrupt, d_denied,
        input  d_ready
    );
endinterface

// File: rtl/tl_ul_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : highest-priority index this cycle
//   gnt_o : one-hot grant, idx_o : granted index, any_o : some request granted
// Searches ptr_i..N-1 first, then 0..ptr_i-1.
module tl_ul_arbiter_rr_pick #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any_o && req_i[j] && j >= int'(ptr_i)) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any_o && req_i[j] && j < int'(ptr_i)) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
    end
endmodule

// File: rtl/tl_ul_arbiter.sv
// N-to-1 TileLink-UL master arbiter.
//   clk, reset_n  : clock, asynchronous active-low reset
//   up (slave)    : NUM_MASTERS upstream master lanes
//   dn (master)   : single downstream port; a_source/d_source carry {master idx, upstream source}
//   err_unmapped  : pulses while a D beat addressed to a non-existent master is dropped
// A channel: round-robin grant, held (LOCKED) until the beat is accepted.
// Each master is limited to MAX_OUTST requests without a D response.
module tl_ul_arbiter
    import tl_ul_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int XLEN        = 32,
    parameter int SID_WIDTH   = 2,
    parameter int MAX_OUTST   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    tl_ul_arbiter_if.slave  up,
    tl_ul_arbiter_if.master dn,
    output logic            err_unmapped
);
    localparam int MIDX_W = $clog2(NUM_MASTERS);
    localparam int OSID_W = SID_WIDTH + MIDX_W;
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [2:0]        size;
        logic [XLEN-1:0]   address;
        logic [XLEN/8-1:0] mask;
        logic [XLEN-1:0]   data;
    } a_fields_t;

    arb_state_t                          state_q, state_d;
    logic [MIDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [MIDX_W-1:0]                   lock_idx_q, lock_idx_d;
    logic [NUM_MASTERS-1:0][CNT_W-1:0]   outst_q, outst_d;

    logic [NUM_MASTERS-1:0]              elig, pick_gnt, lock_oh, d_fire;
    logic [MIDX_W-1:0]                   pick_idx, sel_idx, d_idx;
    logic                                pick_any, sel_vld, a_fire, d_mapped;
    a_fields_t                           a_sel;

    function automatic logic [MIDX_W-1:0] wrap_inc(input logic [MIDX_W-1:0] i);
        return (int'(i) == NUM_MASTERS - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            elig[i]    = up.a_valid[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
            lock_oh[i] = (lock_idx_q == MIDX_W'(i));
        end
    end

    tl_ul_arbiter_rr_pick #(.N(NUM_MASTERS), .W(MIDX_W)) u_pick (
        .req_i (elig),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            outst_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            outst_q    <= outst_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    if (dn.a_ready[0]) begin
                        rr_ptr_d = wrap_inc(pick_idx);
                    end else begin
                        lock_idx_d = pick_idx;
                        state_d    = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                // The locked master bypasses the outstanding cap: it was eligible when granted.
                if (a_fire) begin
                    rr_ptr_d = wrap_inc(lock_idx_q);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (A mux) ----------------
    always_comb begin
        sel_idx = (state_q == ST_LOCKED) ? lock_idx_q : pick_idx;
        // Gated by reset_n so nothing is presented while reset is held.
        sel_vld = reset_n && ((state_q == ST_LOCKED) ? up.a_valid[lock_idx_q] : pick_any);
        a_fire  = sel_vld && dn.a_ready[0];

        a_sel.opcode  = up.a_opcode[sel_idx];
        a_sel.param   = up.a_param[sel_idx];
        a_sel.size    = up.a_size[sel_idx];
        a_sel.address = up.a_address[sel_idx];
        a_sel.mask    = up.a_mask[sel_idx];
        a_sel.data    = up.a_data[sel_idx];

        dn.a_valid[0]   = sel_vld;
        dn.a_opcode[0]  = a_sel.opcode;
        dn.a_param[0]   = a_sel.param;
        dn.a_size[0]    = a_sel.size;
        dn.a_address[0] = a_sel.address;
        dn.a_mask[0]    = a_sel.mask;
        dn.a_data[0]    = a_sel.data;
        dn.a_source[0]  = {sel_idx, up.a_source[sel_idx]};

        up.a_ready = {NUM_MASTERS{sel_vld && dn.a_ready[0]}}
                   & ((state_q == ST_LOCKED) ? lock_oh : pick_gnt);
    end

    // ---------------- D demux ----------------
    always_comb begin
        d_idx        = dn.d_source[0][OSID_W-1:SID_WIDTH];
        d_mapped     = int'(d_idx) < NUM_MASTERS;
        dn.d_ready   = '0;
        up.d_valid   = '0;
        err_unmapped = reset_n && dn.d_valid[0] && !d_mapped;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            up.d_opcode[i]  = dn.d_opcode[0];
            up.d_param[i]   = dn.d_param[0];
            up.d_size[i]    = dn.d_size[0];
            up.d_source[i]  = dn.d_source[0][SID_WIDTH-1:0];
            up.d_data[i]    = dn.d_data[0];
            up.d_corrupt[i] = dn.d_corrupt[0];
            up.d_denied[i]  = dn.d_denied[0];
            if (reset_n && dn.d_valid[0] && d_idx == MIDX_W'(i)) begin
                up.d_valid[i] = 1'b1;
            end
            if (reset_n && d_mapped && d_idx == MIDX_W'(i)) begin
                dn.d_ready[0] = up.d_ready[i];
            end
        end
        // Unmapped beats are sunk so the downstream never stalls on them.
        if (reset_n && !d_mapped) begin
            dn.d_ready[0] = 1'b1;
        end
    end

    assign d_fire = up.d_valid & up.d_ready;

    // ---------------- outstanding counters ----------------
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            case ({a_fire && (sel_idx == MIDX_W'(i)), d_fire[i]})
                2'b10:   outst_d[i] = outst_q[i] + CNT_W'(1);
                2'b01:   outst_d[i] = outst_q[i] - CNT_W'(1);
                default: outst_d[i] = outst_q[i];
            endcase
        end
    end

endmodule

// File: tb/tb_tl_ul_arbiter.sv
module tb_tl_ul_arbiter;
    import tl_ul_arbiter_pkg::*;

    localparam int N    = 2;
    localparam int XLEN = 32;
    localparam int SID  = 2;
    localparam int MAXO = 2;
    localparam int OSID = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic err_unmapped, err3;

    always #5 clk = ~clk;

    tl_ul_arbiter_if #(.N(N), .XLEN(XLEN), .SRC_W(SID))  up_if ();
    tl_ul_arbiter_if #(.N(1), .XLEN(XLEN), .SRC_W(OSID)) dn_if ();
    tl_ul_arbiter_if #(.N(3), .XLEN(XLEN), .SRC_W(SID))  up3_if ();
    tl_ul_arbiter_if #(.N(1), .XLEN(XLEN), .SRC_W(4))    dn3_if ();

    tl_ul_arbiter #(.NUM_MASTERS(N), .XLEN(XLEN), .SID_WIDTH(SID), .MAX_OUTST(MAXO)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .up           (up_if.slave),
        .dn           (dn_if.master),
        .err_unmapped (err_unmapped)
    );

    // Three-master instance: index 3 is unmapped.
    tl_ul_arbiter #(.NUM_MASTERS(3), .XLEN(XLEN), .SID_WIDTH(SID), .MAX_OUTST(MAXO)) u_dut3 (
        .clk          (clk),
        .reset_n      (reset_n),
        .up           (up3_if.slave),
        .dn           (dn3_if.master),
        .err_unmapped (err3)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [OSID-1:0] source;
        logic [2:0]      opcode;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } abeat_t;

    abeat_t a_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every downstream A fire must match the oldest expected beat.
    always @(negedge clk) begin
        abeat_t o, e;
        if (reset_n && dn_if.a_valid[0] && dn_if.a_ready[0]) begin
            o = '{dn_if.a_source[0], dn_if.a_opcode[0], dn_if.a_address[0], dn_if.a_data[0]};
            chk("a_fire_expected", 64'(a_q.size() != 0), 64'd1);
            if (a_q.size() != 0) begin
                e = a_q.pop_front();
                chk("a_beat_source", 64'(o.source), 64'(e.source));
                chk("a_beat_fields", 64'({o.opcode, o.addr}), 64'({e.opcode, e.addr}));
                chk("a_beat_data",   64'(o.data), 64'(e.data));
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drv_a(input int i, input logic v, input logic [2:0] op,
                         input logic [SID-1:0] src, input logic [XLEN-1:0] addr);
        up_if.a_valid[i]   = v;
        up_if.a_opcode[i]  = op;
        up_if.a_param[i]   = 3'd0;
        up_if.a_size[i]    = 3'd2;
        up_if.a_source[i]  = src;
        up_if.a_address[i] = addr;
        up_if.a_mask[i]    = 4'hf;
        up_if.a_data[i]    = ~addr;
    endtask

    task automatic exp_a(input int i, input logic [2:0] op,
                         input logic [SID-1:0] src, input logic [XLEN-1:0] addr);
        abeat_t b;
        logic   mi;
        mi = (i != 0);
        b.source = {mi, src};
        b.opcode = op;
        b.addr   = addr;
        b.data   = ~addr;
        a_q.push_back(b);
    endtask

    task automatic drv_d(input logic v, input logic [OSID-1:0] src, input logic [XLEN-1:0] data);
        dn_if.d_valid[0]   = v;
        dn_if.d_source[0]  = src;
        dn_if.d_opcode[0]  = ACK_DATA;
        dn_if.d_param[0]   = 2'd0;
        dn_if.d_size[0]    = 3'd2;
        dn_if.d_data[0]    = data;
        dn_if.d_corrupt[0] = 1'b0;
        dn_if.d_denied[0]  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        up_if.a_valid = '0; up_if.a_opcode = '0; up_if.a_param = '0; up_if.a_size = '0;
        up_if.a_source = '0; up_if.a_address = '0; up_if.a_mask = '0; up_if.a_data = '0;
        up_if.d_ready = '0;
        dn_if.a_ready = '0;
        drv_d(1'b0, '0, '0);
        up3_if.a_valid = '0; up3_if.a_opcode = '0; up3_if.a_param = '0; up3_if.a_size = '0;
        up3_if.a_source = '0; up3_if.a_address = '0; up3_if.a_mask = '0; up3_if.a_data = '0;
        up3_if.d_ready = '0;
        dn3_if.a_ready = '0;
        dn3_if.d_valid = '0; dn3_if.d_source = '0; dn3_if.d_opcode = '0; dn3_if.d_param = '0;
        dn3_if.d_size = '0; dn3_if.d_data = '0; dn3_if.d_corrupt = '0; dn3_if.d_denied = '0;

        // ---- reset: everything quiet even with live inputs ----
        drv_a(0, 1'b1, GET, 2'd1, 32'h100);
        drv_a(1, 1'b1, GET, 2'd2, 32'h200);
        dn_if.a_ready = 1'b1;
        up_if.d_ready = 2'b11;
        drv_d(1'b1, 3'b0_01, 32'h0);
        #3;
        chk("rst_tl_a_valid", 64'(dn_if.a_valid), 64'd0);
        chk("rst_m_a_ready",  64'(up_if.a_ready), 64'd0);
        chk("rst_m_d_valid",  64'(up_if.d_valid), 64'd0);
        chk("rst_tl_d_ready", 64'(dn_if.d_ready), 64'd0);
        drv_d(1'b0, '0, '0);
        step;
        step;
        reset_n = 1'b1;

        // ---- 1: alternating grants from reset ----
        exp_a(0, GET, 2'd1, 32'h100);
        settle;
        chk("t1_c0_m_a_ready", 64'(up_if.a_ready), 64'b01);
        chk("t1_c0_tl_source", 64'(dn_if.a_source[0]), 64'b0_01);
        step;
        exp_a(1, GET, 2'd2, 32'h200);
        settle;
        chk("t1_c1_m_a_ready", 64'(up_if.a_ready), 64'b10);
        chk("t1_c1_tl_source", 64'(dn_if.a_source[0]), 64'b1_10);
        step;
        drv_a(0, 1'b1, GET, 2'd3, 32'h104);
        exp_a(0, GET, 2'd3, 32'h104);
        settle;
        chk("t1_c2_m_a_ready", 64'(up_if.a_ready), 64'b01);
        step;

        // drain: outst0=2, outst1=1 -> 0
        drv_a(0, 1'b0, GET, 2'd0, 32'h0);
        drv_a(1, 1'b0, GET, 2'd0, 32'h0);
        drv_d(1'b1, 3'b0_01, 32'hd0d0_0001);
        settle;
        chk("drain_tl_a_valid", 64'(dn_if.a_valid), 64'd0);
        chk("drain0_m_d_valid", 64'(up_if.d_valid), 64'b01);
        chk("drain0_m_d_src",   64'(up_if.d_source[0]), 64'b01);
        chk("drain0_m_d_data",  64'(up_if.d_data[0]), 64'hd0d0_0001);
        chk("drain0_tl_d_rdy",  64'(dn_if.d_ready), 64'd1);
        step;
        drv_d(1'b1, 3'b0_11, 32'hd0d0_0002);
        settle;
        chk("drain1_m_d_valid", 64'(up_if.d_valid), 64'b01);
        step;
        drv_d(1'b1, 3'b1_10, 32'hd0d0_0003);
        settle;
        chk("drain2_m_d_valid", 64'(up_if.d_valid), 64'b10);
        chk("drain2_m_d_src",   64'(up_if.d_source[1]), 64'b10);
        chk("drain2_err",       64'(err_unmapped), 64'd0);
        step;
        drv_d(1'b0, '0, '0);

        // ---- 2: lock on M1 under backpressure ----
        dn_if.a_ready = 1'b0;
        drv_a(1, 1'b1, PUT_FULL, 2'd1, 32'h400);
        settle;
        chk("t2_lock_valid",   64'(dn_if.a_valid), 64'd1);
        chk("t2_lock_src",     64'(dn_if.a_source[0]), 64'b1_01);
        chk("t2_lock_m_ready", 64'(up_if.a_ready), 64'b00);
        step;
        drv_a(0, 1'b1, GET, 2'd0, 32'h500);
        for (int k = 1; k < 3; k++) begin
            settle;
            chk("t2_hold_src",     64'(dn_if.a_source[0]), 64'b1_01);
            chk("t2_hold_addr",    64'(dn_if.a_address[0]), 64'h400);
            chk("t2_hold_m_ready", 64'(up_if.a_ready), 64'b00);
            step;
        end
        dn_if.a_ready = 1'b1;
        exp_a(1, PUT_FULL, 2'd1, 32'h400);
        settle;
        chk("t2_fire_m_ready", 64'(up_if.a_ready), 64'b10);
        step;
        drv_a(1, 1'b0, GET, 2'd0, 32'h0);
        exp_a(0, GET, 2'd0, 32'h500);
        settle;
        chk("t2_next_m0", 64'(up_if.a_ready), 64'b01);
        step;

        // ---- 5: simultaneous A and D fire on M0 at outst=1 ----
        drv_a(0, 1'b1, GET, 2'd1, 32'h600);
        exp_a(0, GET, 2'd1, 32'h600);
        drv_d(1'b1, 3'b0_00, 32'hd0d0_0005);
        settle;
        chk("t5_m_a_ready", 64'(up_if.a_ready), 64'b01);
        chk("t5_m_d_valid", 64'(up_if.d_valid), 64'b01);
        chk("t5_tl_d_rdy",  64'(dn_if.d_ready), 64'd1);
        step;
        drv_d(1'b0, '0, '0);

        // ---- 3: outstanding cap on M0 ----
        drv_a(0, 1'b1, GET, 2'd2, 32'h700);
        exp_a(0, GET, 2'd2, 32'h700);
        settle;
        chk("t3_second_get", 64'(up_if.a_ready), 64'b01);
        step;
        drv_a(0, 1'b1, GET, 2'd3, 32'h704);
        settle;
        chk("t3_stall_valid", 64'(dn_if.a_valid), 64'd0);
        chk("t3_stall_ready", 64'(up_if.a_ready), 64'b00);
        step;
        drv_a(1, 1'b1, GET, 2'd0, 32'h800);
        exp_a(1, GET, 2'd0, 32'h800);
        settle;
        chk("t3_m1_served", 64'(up_if.a_ready), 64'b10);
        step;
        drv_a(1, 1'b0, GET, 2'd0, 32'h0);
        drv_d(1'b1, 3'b0_01, 32'hd0d0_0006);
        settle;
        chk("t3_dret_a_valid", 64'(dn_if.a_valid), 64'd0);
        chk("t3_dret_d_valid", 64'(up_if.d_valid), 64'b01);
        step;
        drv_d(1'b0, '0, '0);
        exp_a(0, GET, 2'd3, 32'h704);
        settle;
        chk("t3_reenabled", 64'(up_if.a_ready), 64'b01);
        step;
        drv_a(0, 1'b0, GET, 2'd0, 32'h0);

        // ---- 4: D routed to M1 with backpressure ----
        up_if.d_ready = 2'b01;
        drv_d(1'b1, 3'b1_01, 32'hd0d0_0007);
        for (int k = 0; k < 2; k++) begin
            settle;
            chk("t4_m_d_valid", 64'(up_if.d_valid), 64'b10);
            chk("t4_m_d_src",   64'(up_if.d_source[1]), 64'b01);
            chk("t4_tl_d_rdy",  64'(dn_if.d_ready), 64'd0);
            step;
        end
        up_if.d_ready = 2'b11;
        settle;
        chk("t4_release_rdy", 64'(dn_if.d_ready), 64'd1);
        step;
        drv_d(1'b0, '0, '0);

        // ---- unmapped D index on the 3-master instance ----
        up3_if.d_ready = 3'b111;
        dn3_if.d_valid[0] = 1'b1;
        dn3_if.d_source[0] = 4'b11_01;
        settle;
        chk("unm_err",       64'(err3), 64'd1);
        chk("unm_tl_d_rdy",  64'(dn3_if.d_ready), 64'd1);
        chk("unm_m_d_valid", 64'(up3_if.d_valid), 64'b000);
        step;
        dn3_if.d_source[0] = 4'b10_11;
        settle;
        chk("map2_err",       64'(err3), 64'd0);
        chk("map2_m_d_valid", 64'(up3_if.d_valid), 64'b100);
        chk("map2_m_d_src",   64'(up3_if.d_source[2]), 64'b11);
        step;
        dn3_if.d_valid[0] = 1'b0;

        // ---- 6: reset while LOCKED with M0 full ----
        dn_if.a_ready = 1'b0;
        drv_a(0, 1'b1, GET, 2'd3, 32'h904);
        drv_a(1, 1'b1, GET, 2'd2, 32'h900);
        settle;
        chk("t6_lock_src",   64'(dn_if.a_source[0]), 64'b1_10);
        chk("t6_lock_ready", 64'(up_if.a_ready), 64'b00);
        step;
        reset_n = 1'b0;
        dn_if.a_ready = 1'b1;
        drv_d(1'b1, 3'b0_00, 32'h0);
        #1;
        chk("t6_rst_a_valid", 64'(dn_if.a_valid), 64'd0);
        chk("t6_rst_a_ready", 64'(up_if.a_ready), 64'd0);
        chk("t6_rst_d_valid", 64'(up_if.d_valid), 64'd0);
        chk("t6_rst_d_ready", 64'(dn_if.d_ready), 64'd0);
        step;
        drv_d(1'b0, '0, '0);
        reset_n = 1'b1;
        exp_a(0, GET, 2'd3, 32'h904);
        settle;
        chk("t6_post_c0", 64'(up_if.a_ready), 64'b01);
        step;
        exp_a(1, GET, 2'd2, 32'h900);
        settle;
        chk("t6_post_c1", 64'(up_if.a_ready), 64'b10);
        step;
        drv_a(0, 1'b1, PUT_PARTIAL, 2'd0, 32'hA00);
        exp_a(0, PUT_PARTIAL, 2'd0, 32'hA00);
        settle;
        chk("t6_post_c2", 64'(up_if.a_ready), 64'b01);
        step;
        drv_a(1, 1'b1, GET, 2'd1, 32'hA04);
        exp_a(1, GET, 2'd1, 32'hA04);
        settle;
        chk("t6_post_c3", 64'(up_if.a_ready), 64'b10);
        step;
        drv_a(0, 1'b0, GET, 2'd0, 32'h0);
        drv_a(1, 1'b0, GET, 2'd0, 32'h0);
        step;

        chk("a_queue_drained", 64'(a_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
